cdb_arbiter: RTL and testbench
==============================

CDB_ARBITER -- requirements
Module: cdb_arbiter

Interface
REQ-001 Parameter IDX_W, default 5, width of a ROB entry index (32-entry ROB).
REQ-002 Parameter DEPTH, default 2, number of entries in each per-source result FIFO.
REQ-003 clk  in  1  single clock; all state changes on the rising edge.
REQ-004 rst  in  1  reset, synchronous and active-high.
REQ-005 rdy  in  1  global clock enable; while low, all state holds.
REQ-006 clear  in  1  mispredict flush; drops all in-flight results.
REQ-007 alu_valid  in  1  ALU/RS result offered this cycle.
REQ-008 alu_ready  out  1  ALU FIFO can accept an entry.
REQ-009 alu_rob  in  IDX_W  destination ROB index of the ALU result.
REQ-010 alu_value  in  32  ALU result value.
REQ-011 alu_topc  in  32  resolved branch target.
REQ-012 alu_topc_valid  in  1  alu_topc is meaningful (branch/JALR).
REQ-013 lsb_valid  in  1  load/store-buffer result offered.
REQ-014 lsb_ready  out  1  LSB FIFO can accept an entry.
REQ-015 lsb_rob  in  IDX_W  destination ROB index of the LSB result.
REQ-016 lsb_value  in  32  LSB result value.
REQ-017 cdb_valid  out  1  one broadcast on the common data bus this cycle.
REQ-018 cdb_rob  out  IDX_W  ROB index being written.
REQ-019 cdb_value  out  32  value written to the ROB and forwarded to RS/SLB.
REQ-020 cdb_topc  out  32  target-PC update.
REQ-021 cdb_topc_valid  out  1  the ROB shall overwrite its topc field.

Function
REQ-022 An entry shall be accepted into a source FIFO at a rising edge only when x_valid, x_ready and rdy are all high and clear and rst are both low.
REQ-023 x_ready shall equal rdy && !clear && (count_x != DEPTH); an entry shall not be pushed into a full FIFO even when that FIFO pops in the same cycle.
REQ-024 Each FIFO shall be a circular buffer with a log2(DEPTH)-bit read pointer and write pointer that wrap modulo DEPTH, plus a count that ranges 0..DEPTH.
REQ-025 Each cycle with rdy high and clear low, the block shall select at most one non-empty FIFO: if only one is non-empty, select it; if both are non-empty, select the source not equal to last_grant.
REQ-026 The selected FIFO head shall be popped and registered onto the cdb_* outputs, with cdb_valid=1 in the next cycle and last_grant updated to that source.
REQ-027 If neither FIFO is non-empty, cdb_valid shall be 0 in the next cycle.
REQ-028 Minimum latency shall be 2 cycles: an entry accepted at the end of cycle n shall appear with cdb_valid=1 in cycle n+2.
REQ-029 cdb_valid shall be high for exactly one enabled cycle per accepted result; there shall be no duplicates and no losses absent clear.
REQ-030 An LSB-sourced broadcast shall drive cdb_topc=0 and cdb_topc_valid=0.
REQ-031 An ALU-sourced broadcast shall carry the alu_topc and alu_topc_valid captured at acceptance.
REQ-032 A simultaneous push and pop on the same non-full FIFO shall leave its count unchanged and preserve FIFO order.
REQ-033 With clear high (and rdy high), the next edge shall empty both FIFOs (count=0, pointers=0), set cdb_valid=0 and set last_grant=LSB; inputs offered in that cycle shall be dropped.
REQ-034 With rdy low, pointers, counts, last_grant and all cdb_* registers shall hold; x_ready shall be 0.
REQ-035 Priority shall be rst > !rdy > clear > normal operation.
REQ-036 The block shall not check for duplicate ROB indices.

Reset
REQ-037 On reset, cdb_valid=0, cdb_rob=0, cdb_value=0, cdb_topc=0, cdb_topc_valid=0, all FIFO counts and pointers=0, and last_grant=LSB (ALU wins the first contention).
REQ-038 Reset asserted mid-operation shall discard all queued results at that edge, regardless of rdy or clear.

Structure
REQ-039 IDX_W, the source encodings (SRC_ALU=0, SRC_LSB=1) and the CDB payload field widths shall live in the shared CPU definitions package.
REQ-040 The per-source FIFO shall be one sub-module, cdb_fifo, parameterised by payload width and DEPTH, instantiated twice.
REQ-041 All outputs shall be registered; no combinational path shall exist from x_valid to cdb_*.

Verification
REQ-042 Single ALU result: after reset, ALU {rob=3, value=0x11, topc=0x100, topc_valid=1} accepted in cycle 1 -> cycle 3 shows cdb_valid=1, rob=3, value=0x11, topc=0x100, topc_valid=1; cycle 4 shows cdb_valid=0.
REQ-043 Contention: ALU rob=4 and LSB rob=5 accepted together in cycle 1 -> rob=4 broadcast in cycle 3, rob=5 in cycle 4; a repeat pair starting cycle 5 -> rob=4 in cycle 7, rob=5 in cycle 8 (round-robin alternates, no starvation).
REQ-044 Full and wrap: LSB pushes rob 1, 2, 3 in consecutive cycles while ALU streams continuously -> lsb_ready=0 exactly when count=2, all three LSB values emerge in order, and the pointers wrap correctly.
REQ-045 Flush: queue 2 ALU + 1 LSB entries, then assert clear for 1 cycle -> no cdb_valid after the flush edge, alu_ready=lsb_ready=0 during the clear cycle, and a new ALU rob=9 accepted next cycle broadcasts 2 cycles later.
REQ-046 Stall: drop rdy for 3 cycles while cdb_valid=1 with rob=7 and one entry is queued -> outputs frozen, x_ready=0; when rdy rises, the queued entry broadcasts next cycle and no entry is lost or duplicated.
REQ-047 Reset mid-stream: assert rst with both FIFOs full -> next cycle all outputs 0, counts 0, and the first contention afterwards grants ALU.

Source files
------------

// File: rtl/cdb_arbiter_pkg.sv
// Shared CPU definitions for the common data bus: ROB index width, payload widths
// and the encoding used to remember which result source was granted last.
package cdb_arbiter_pkg;

    localparam int IDX_W   = 5;
    localparam int VALUE_W = 32;
    localparam int TOPC_W  = 32;

    typedef enum logic {
        SRC_ALU = 1'b0,
        SRC_LSB = 1'b1
    } src_e;

endpackage

// File: rtl/cdb_fifo.sv
// Small circular result FIFO feeding the CDB arbiter; acceptance is gated by the
// global enable and the flush so the arbiter never sees a half-flushed queue.
module cdb_fifo
    import cdb_arbiter_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rdy,
    input  logic             clear,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             ready,
    output logic             not_empty
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [CNT_W-1:0] count;
    logic             do_push;
    logic             do_pop;

    // A full FIFO refuses a push even if it pops in the same cycle.
    assign ready     = rdy && !clear && (count != CNT_W'(DEPTH));
    assign not_empty = (count != '0);
    assign do_push   = push && ready;
    assign do_pop    = pop && not_empty && rdy && !clear;
    assign dout      = mem[rd_ptr];

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (rdy) begin
            if (clear) begin
                rd_ptr <= '0;
                wr_ptr <= '0;
                count  <= '0;
            end else begin
                if (do_push) begin
                    wr_ptr <= next_ptr(wr_ptr);
                end
                if (do_pop) begin
                    rd_ptr <= next_ptr(rd_ptr);
                end
                case ({do_push, do_pop})
                    2'b10:   count <= count + 1'b1;
                    2'b01:   count <= count - 1'b1;
                    default: count <= count;
                endcase
            end
        end
    end

endmodule

// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: merges ALU and load/store results onto one registered
// broadcast per cycle, alternating between sources when both have work queued.
module cdb_arbiter #(
    parameter int IDX_W = cdb_arbiter_pkg::IDX_W,
    parameter int DEPTH = 2
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               rdy,
    input  logic                               clear,
    input  logic                               alu_valid,
    output logic                               alu_ready,
    input  logic [IDX_W-1:0]                   alu_rob,
    input  logic [cdb_arbiter_pkg::VALUE_W-1:0] alu_value,
    input  logic [cdb_arbiter_pkg::TOPC_W-1:0]  alu_topc,
    input  logic                               alu_topc_valid,
    input  logic                               lsb_valid,
    output logic                               lsb_ready,
    input  logic [IDX_W-1:0]                   lsb_rob,
    input  logic [cdb_arbiter_pkg::VALUE_W-1:0] lsb_value,
    output logic                               cdb_valid,
    output logic [IDX_W-1:0]                   cdb_rob,
    output logic [cdb_arbiter_pkg::VALUE_W-1:0] cdb_value,
    output logic [cdb_arbiter_pkg::TOPC_W-1:0]  cdb_topc,
    output logic                               cdb_topc_valid
);
    import cdb_arbiter_pkg::*;

    typedef struct packed {
        logic [IDX_W-1:0]   rob;
        logic [VALUE_W-1:0] value;
        logic [TOPC_W-1:0]  topc;
        logic               topc_valid;
    } alu_entry_t;

    typedef struct packed {
        logic [IDX_W-1:0]   rob;
        logic [VALUE_W-1:0] value;
    } lsb_entry_t;

    alu_entry_t alu_in;
    alu_entry_t alu_head;
    lsb_entry_t lsb_in;
    lsb_entry_t lsb_head;
    logic       alu_ne;
    logic       lsb_ne;
    logic       grant_alu;
    logic       grant_lsb;
    src_e       last_grant;

    assign alu_in = {alu_rob, alu_value, alu_topc, alu_topc_valid};
    assign lsb_in = {lsb_rob, lsb_value};

    cdb_fifo #(.WIDTH($bits(alu_entry_t)), .DEPTH(DEPTH)) u_alu_fifo (
        .clk       (clk),
        .rst       (rst),
        .rdy       (rdy),
        .clear     (clear),
        .push      (alu_valid),
        .pop       (grant_alu),
        .din       (alu_in),
        .dout      (alu_head),
        .ready     (alu_ready),
        .not_empty (alu_ne)
    );

    cdb_fifo #(.WIDTH($bits(lsb_entry_t)), .DEPTH(DEPTH)) u_lsb_fifo (
        .clk       (clk),
        .rst       (rst),
        .rdy       (rdy),
        .clear     (clear),
        .push      (lsb_valid),
        .pop       (grant_lsb),
        .din       (lsb_in),
        .dout      (lsb_head),
        .ready     (lsb_ready),
        .not_empty (lsb_ne)
    );

    // Round-robin only matters under contention; otherwise take whoever has work.
    always_comb begin
        grant_alu = 1'b0;
        grant_lsb = 1'b0;
        if (alu_ne && lsb_ne) begin
            if (last_grant == SRC_ALU) begin
                grant_lsb = 1'b1;
            end else begin
                grant_alu = 1'b1;
            end
        end else if (alu_ne) begin
            grant_alu = 1'b1;
        end else if (lsb_ne) begin
            grant_lsb = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cdb_valid      <= 1'b0;
            cdb_rob        <= '0;
            cdb_value      <= '0;
            cdb_topc       <= '0;
            cdb_topc_valid <= 1'b0;
            last_grant     <= SRC_LSB;
        end else if (rdy) begin
            if (clear) begin
                cdb_valid  <= 1'b0;
                last_grant <= SRC_LSB;
            end else if (grant_alu) begin
                cdb_valid      <= 1'b1;
                cdb_rob        <= alu_head.rob;
                cdb_value      <= alu_head.value;
                cdb_topc       <= alu_head.topc;
                cdb_topc_valid <= alu_head.topc_valid;
                last_grant     <= SRC_ALU;
            end else if (grant_lsb) begin
                // Loads/stores never redirect the PC.
                cdb_valid      <= 1'b1;
                cdb_rob        <= lsb_head.rob;
                cdb_value      <= lsb_head.value;
                cdb_topc       <= '0;
                cdb_topc_valid <= 1'b0;
                last_grant     <= SRC_LSB;
            end else begin
                cdb_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Self-checking bench for cdb_arbiter: per-source scoreboards plus directed
// cycle-accurate checks of latency, round-robin, flush, stall and reset.
module tb_cdb_arbiter;

    localparam int IW = 5;

    logic          clk = 1'b0;
    logic          rst;
    logic          rdy;
    logic          clear;
    logic          alu_valid;
    logic          alu_ready;
    logic [IW-1:0] alu_rob;
    logic [31:0]   alu_value;
    logic [31:0]   alu_topc;
    logic          alu_topc_valid;
    logic          lsb_valid;
    logic          lsb_ready;
    logic [IW-1:0] lsb_rob;
    logic [31:0]   lsb_value;
    logic          cdb_valid;
    logic [IW-1:0] cdb_rob;
    logic [31:0]   cdb_value;
    logic [31:0]   cdb_topc;
    logic          cdb_topc_valid;

    typedef struct {
        logic [IW-1:0] rob;
        logic [31:0]   value;
        logic [31:0]   topc;
        logic          topc_valid;
    } exp_t;

    exp_t alu_q[$];
    exp_t lsb_q[$];
    exp_t mon_e;
    int   total_count = 0;
    int   bad_count   = 0;

    cdb_arbiter #(.IDX_W(IW), .DEPTH(2)) dut (
        .clk            (clk),
        .rst            (rst),
        .rdy            (rdy),
        .clear          (clear),
        .alu_valid      (alu_valid),
        .alu_ready      (alu_ready),
        .alu_rob        (alu_rob),
        .alu_value      (alu_value),
        .alu_topc       (alu_topc),
        .alu_topc_valid (alu_topc_valid),
        .lsb_valid      (lsb_valid),
        .lsb_ready      (lsb_ready),
        .lsb_rob        (lsb_rob),
        .lsb_value      (lsb_value),
        .cdb_valid      (cdb_valid),
        .cdb_rob        (cdb_rob),
        .cdb_value      (cdb_value),
        .cdb_topc       (cdb_topc),
        .cdb_topc_valid (cdb_topc_valid)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        total_count++;
        if (actual !== expected) begin
            bad_count++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic av, input logic [IW-1:0] ar, input logic [31:0] aval,
                                 input logic [31:0] atopc, input logic atv,
                                 input logic lv, input logic [IW-1:0] lr, input logic [31:0] lval);
        alu_valid      = av;
        alu_rob        = ar;
        alu_value      = aval;
        alu_topc       = atopc;
        alu_topc_valid = atv;
        lsb_valid      = lv;
        lsb_rob        = lr;
        lsb_value      = lval;
    endtask

    task automatic idle();
        applyStimulus(1'b0, '0, 32'd0, 32'd0, 1'b0, 1'b0, '0, 32'd0);
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst   = 1'b1;
        rdy   = 1'b1;
        clear = 1'b0;
        idle();
        next_cycle();
        rst = 1'b0;
    endtask

    task automatic expect_bus(input string tag, input logic v, input logic [IW-1:0] r);
        sample();
        checkOutput({tag, "_valid"}, 64'(cdb_valid), 64'(v));
        if (v) begin
            checkOutput({tag, "_rob"}, 64'(cdb_rob), 64'(r));
        end
        next_cycle();
    endtask

    task automatic check_zero_outputs(input string tag);
        checkOutput({tag, "_valid"}, 64'(cdb_valid), 64'd0);
        checkOutput({tag, "_rob"}, 64'(cdb_rob), 64'd0);
        checkOutput({tag, "_value"}, 64'(cdb_value), 64'd0);
        checkOutput({tag, "_topc"}, 64'(cdb_topc), 64'd0);
        checkOutput({tag, "_topc_valid"}, 64'(cdb_topc_valid), 64'd0);
        checkOutput({tag, "_alu_ready"}, 64'(alu_ready), 64'd1);
        checkOutput({tag, "_lsb_ready"}, 64'(lsb_ready), 64'd1);
    endtask

    // Scoreboard: record accepted entries per source, compare each enabled broadcast.
    always @(negedge clk) begin
        if (rst || (rdy && clear)) begin
            alu_q.delete();
            lsb_q.delete();
        end else if (rdy) begin
            if (cdb_valid) begin
                if (cdb_topc_valid) begin
                    if (alu_q.size() == 0) begin
                        checkOutput("sb_alu_spurious", 64'(cdb_valid), 64'd0);
                    end else begin
                        mon_e = alu_q.pop_front();
                        checkOutput("sb_alu_rob", 64'(cdb_rob), 64'(mon_e.rob));
                        checkOutput("sb_alu_value", 64'(cdb_value), 64'(mon_e.value));
                        checkOutput("sb_alu_topc", 64'(cdb_topc), 64'(mon_e.topc));
                    end
                end else begin
                    if (lsb_q.size() == 0) begin
                        checkOutput("sb_lsb_spurious", 64'(cdb_valid), 64'd0);
                    end else begin
                        mon_e = lsb_q.pop_front();
                        checkOutput("sb_lsb_rob", 64'(cdb_rob), 64'(mon_e.rob));
                        checkOutput("sb_lsb_value", 64'(cdb_value), 64'(mon_e.value));
                        checkOutput("sb_lsb_topc", 64'(cdb_topc), 64'(mon_e.topc));
                    end
                end
            end
            if (alu_valid && alu_ready) begin
                alu_q.push_back('{alu_rob, alu_value, alu_topc, alu_topc_valid});
            end
            if (lsb_valid && lsb_ready) begin
                lsb_q.push_back('{lsb_rob, lsb_value, 32'd0, 1'b0});
            end
        end
    end

    logic lsb_ready_tbl [6] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    int   ai;
    int   li;

    initial begin
        // Reset state and single ALU result
        do_reset();
        sample();
        check_zero_outputs("reset");
        next_cycle();
        applyStimulus(1'b1, 5'd3, 32'h11, 32'h100, 1'b1, 1'b0, '0, 32'd0);
        next_cycle();
        idle();
        expect_bus("single_c2", 1'b0, '0);
        sample();
        checkOutput("single_valid", 64'(cdb_valid), 64'd1);
        checkOutput("single_rob", 64'(cdb_rob), 64'd3);
        checkOutput("single_value", 64'(cdb_value), 64'h11);
        checkOutput("single_topc", 64'(cdb_topc), 64'h100);
        checkOutput("single_topc_valid", 64'(cdb_topc_valid), 64'd1);
        next_cycle();
        expect_bus("single_c4", 1'b0, '0);

        // Contention and round-robin alternation
        do_reset();
        applyStimulus(1'b1, 5'd4, 32'h44, 32'h400, 1'b1, 1'b1, 5'd5, 32'h55);
        next_cycle();
        idle();
        next_cycle();
        expect_bus("cont_c3", 1'b1, 5'd4);
        sample();
        checkOutput("cont_c4_rob", 64'(cdb_rob), 64'd5);
        checkOutput("cont_c4_topc", 64'(cdb_topc), 64'd0);
        checkOutput("cont_c4_topc_valid", 64'(cdb_topc_valid), 64'd0);
        next_cycle();
        applyStimulus(1'b1, 5'd4, 32'h46, 32'h404, 1'b1, 1'b1, 5'd5, 32'h57);
        next_cycle();
        idle();
        expect_bus("cont_c6", 1'b0, '0);
        expect_bus("cont_c7", 1'b1, 5'd4);
        expect_bus("cont_c8", 1'b1, 5'd5);

        // Full LSB FIFO, pointer wrap, ALU streaming
        do_reset();
        ai = 0;
        li = 0;
        for (int cyc = 0; cyc < 20; cyc++) begin
            applyStimulus(ai < 6, IW'(10 + ai), 32'h1000 + 32'(ai), 32'h2000 + 32'(ai), 1'b1,
                          li < 3, IW'(1 + li), 32'h500 + 32'(li));
            sample();
            if (cyc < 6) begin
                checkOutput($sformatf("stream_lsb_ready_c%0d", cyc + 1), 64'(lsb_ready), 64'(lsb_ready_tbl[cyc]));
            end
            if (alu_valid && alu_ready) ai++;
            if (lsb_valid && lsb_ready) li++;
            next_cycle();
        end
        idle();
        checkOutput("stream_alu_accepted", 64'(ai), 64'd6);
        checkOutput("stream_lsb_accepted", 64'(li), 64'd3);

        // Flush
        do_reset();
        applyStimulus(1'b1, 5'd20, 32'h20, 32'h200, 1'b1, 1'b1, 5'd21, 32'h21);
        next_cycle();
        applyStimulus(1'b1, 5'd22, 32'h22, 32'h220, 1'b1, 1'b0, '0, 32'd0);
        next_cycle();
        clear = 1'b1;
        applyStimulus(1'b1, 5'd30, 32'h30, 32'h300, 1'b1, 1'b1, 5'd31, 32'h31);
        sample();
        checkOutput("flush_alu_ready", 64'(alu_ready), 64'd0);
        checkOutput("flush_lsb_ready", 64'(lsb_ready), 64'd0);
        next_cycle();
        clear = 1'b0;
        applyStimulus(1'b1, 5'd9, 32'h99, 32'h900, 1'b1, 1'b0, '0, 32'd0);
        expect_bus("flush_c4", 1'b0, '0);
        idle();
        expect_bus("flush_c5", 1'b0, '0);
        sample();
        checkOutput("flush_new_valid", 64'(cdb_valid), 64'd1);
        checkOutput("flush_new_rob", 64'(cdb_rob), 64'd9);
        checkOutput("flush_new_value", 64'(cdb_value), 64'h99);
        next_cycle();
        expect_bus("flush_c7", 1'b0, '0);

        // Stall with a broadcast showing and one entry queued
        do_reset();
        applyStimulus(1'b1, 5'd7, 32'h77, 32'h700, 1'b1, 1'b1, 5'd8, 32'h88);
        next_cycle();
        idle();
        next_cycle();
        for (int k = 0; k < 3; k++) begin
            rdy = 1'b0;
            applyStimulus(1'b1, 5'd12, 32'hC, 32'hC00, 1'b1, 1'b0, '0, 32'd0);
            sample();
            checkOutput($sformatf("stall%0d_valid", k), 64'(cdb_valid), 64'd1);
            checkOutput($sformatf("stall%0d_rob", k), 64'(cdb_rob), 64'd7);
            checkOutput($sformatf("stall%0d_alu_ready", k), 64'(alu_ready), 64'd0);
            checkOutput($sformatf("stall%0d_lsb_ready", k), 64'(lsb_ready), 64'd0);
            next_cycle();
        end
        rdy = 1'b1;
        idle();
        expect_bus("stall_resume", 1'b1, 5'd7);
        expect_bus("stall_queued", 1'b1, 5'd8);
        expect_bus("stall_after", 1'b0, '0);

        // Reset in the middle of traffic
        do_reset();
        applyStimulus(1'b1, 5'd16, 32'h16, 32'h160, 1'b1, 1'b1, 5'd17, 32'h17);
        next_cycle();
        applyStimulus(1'b1, 5'd18, 32'h18, 32'h180, 1'b1, 1'b1, 5'd19, 32'h19);
        next_cycle();
        rst = 1'b1;
        applyStimulus(1'b1, 5'd20, 32'h20, 32'h200, 1'b1, 1'b1, 5'd21, 32'h21);
        next_cycle();
        rst = 1'b0;
        idle();
        sample();
        check_zero_outputs("midrst");
        next_cycle();
        applyStimulus(1'b1, 5'd24, 32'h24, 32'h240, 1'b1, 1'b1, 5'd25, 32'h25);
        expect_bus("midrst_c5", 1'b0, '0);
        idle();
        expect_bus("midrst_c6", 1'b0, '0);
        expect_bus("midrst_alu_first", 1'b1, 5'd24);
        expect_bus("midrst_lsb_second", 1'b1, 5'd25);
        expect_bus("midrst_drained", 1'b0, '0);

        next_cycle();
        next_cycle();
        checkOutput("alu_q_drained", 64'(alu_q.size()), 64'd0);
        checkOutput("lsb_q_drained", 64'(lsb_q.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total_count, bad_count);
        $finish;
    end

endmodule
